// File: rtl/countdown_timer.sv
// countdown_timer: loadable two-digit BCD down-counting round timer.
// A clock-enable prescaler produces one count step every TICK_DIV cycles;
// the count decrements toward 00 and signals round end.
// Optional build macro: COUNTDOWN_AUTORELOAD_EN -- on reaching 00, reload the
// stored value and keep running instead of entering DONE (unless the stored
// value is 00).
module countdown_timer #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       done,
    output logic       expired
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [PRE_W-1:0] pre, pre_n;
    logic [3:0]       tens_n, ones_n;
    logic             expired_n;
`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [3:0]       rel_tens, rel_ones, rel_tens_n, rel_ones_n;
`endif

    // Digit values above 9 are clamped to 9 on load.
    function automatic logic [3:0] sat_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // State, count, prescaler and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pre     <= '0;
            tens    <= 4'd0;
            ones    <= 4'd0;
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            rel_tens <= 4'd0;
            rel_ones <= 4'd0;
`endif
        end else begin
            state   <= state_n;
            pre     <= pre_n;
            tens    <= tens_n;
            ones    <= ones_n;
            running <= (state_n == RUN);
            done    <= (state_n == DONE);
            expired <= expired_n;
`ifdef COUNTDOWN_AUTORELOAD_EN
            rel_tens <= rel_tens_n;
            rel_ones <= rel_ones_n;
`endif
        end
    end

    // Next-state, next-count and expiry; priority load > pause > start > tick.
    always_comb begin
        logic [3:0] dec_tens;
        logic [3:0] dec_ones;
        logic       reach_zero;

        state_n    = state;
        pre_n      = pre;
        tens_n     = tens;
        ones_n     = ones;
        expired_n  = 1'b0;
        reach_zero = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
        rel_tens_n = rel_tens;
        rel_ones_n = rel_ones;
`endif

        // Digit-wise BCD decrement with borrow from tens.
        if (ones != 4'd0) begin
            dec_ones = ones - 4'd1;
            dec_tens = tens;
        end else begin
            dec_ones = 4'd9;
            dec_tens = tens - 4'd1;
        end

        if (load) begin
            tens_n  = sat_bcd(load_tens);
            ones_n  = sat_bcd(load_ones);
            pre_n   = '0;
            state_n = IDLE;
`ifdef COUNTDOWN_AUTORELOAD_EN
            rel_tens_n = sat_bcd(load_tens);
            rel_ones_n = sat_bcd(load_ones);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!pause && start) begin
                        if (tens == 4'd0 && ones == 4'd0) begin
                            reach_zero = 1'b1;
                        end else begin
                            state_n = RUN;
                            pre_n   = '0;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_n = PAUSE;
                    end else if (pre == PRE_LAST) begin
                        pre_n  = '0;
                        tens_n = dec_tens;
                        ones_n = dec_ones;
                        if (dec_tens == 4'd0 && dec_ones == 4'd0) begin
                            reach_zero = 1'b1;
                        end
                    end else begin
                        pre_n = pre + PRE_W'(1);
                    end
                end
                PAUSE: begin
                    if (!pause && start) begin
                        state_n = RUN;
                    end
                end
                default: begin
                end
            endcase

            // Count reached 00: pulse expired and either stop or reload.
            if (reach_zero) begin
                expired_n = 1'b1;
                state_n   = DONE;
                tens_n    = 4'd0;
                ones_n    = 4'd0;
`ifdef COUNTDOWN_AUTORELOAD_EN
                if (rel_tens != 4'd0 || rel_ones != 4'd0) begin
                    state_n = RUN;
                    pre_n   = '0;
                    tens_n  = rel_tens;
                    ones_n  = rel_ones;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed bench for countdown_timer with TICK_DIV=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_countdown_timer;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic       start;
    logic       pause;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       done;
    logic       expired;

    int vectors;
    int miscompares;

    countdown_timer #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_tens (load_tens),
        .load_ones (load_ones),
        .start     (start),
        .pause     (pause),
        .tens      (tens),
        .ones      (ones),
        .running   (running),
        .done      (done),
        .expired   (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 unit after the last one.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare {tens, ones, running, done, expired} against the expected tuple.
    task automatic chk(input string tag, input logic [3:0] et, input logic [3:0] eo,
                       input logic er, input logic ed, input logic ee);
        logic [10:0] obs;
        logic [10:0] exp_v;
        obs   = {tens, ones, running, done, expired};
        exp_v = {et, eo, er, ed, ee};
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed tens=%0d ones=%0d run=%b done=%b exp=%b expected tens=%0d ones=%0d run=%b done=%b exp=%b",
                   tag, obs[10:7], obs[6:3], obs[2], obs[1], obs[0],
                   exp_v[10:7], exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        load = 1'b1; load_tens = t; load_ones = o;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1; load = 1'b0; load_tens = 4'd0; load_ones = 4'd0;
        start = 1'b0; pause = 1'b0;
        #1;
        cyc(2);
        chk("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

`ifndef COUNTDOWN_AUTORELOAD_EN
        // Load 02, start one cycle later, count to 00.
        do_load(4'd0, 4'd2);
        chk("load02", 4'd0, 4'd2, 1'b0, 1'b0, 1'b0);
        cyc(1);
        chk("idle_hold", 4'd0, 4'd2, 1'b0, 1'b0, 1'b0);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("start02", 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
        cyc(3);
        chk("pre_tick", 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
        cyc(1);
        chk("first_dec", 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        cyc(3);
        chk("before_zero", 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        cyc(1);
        chk("reach_zero", 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        cyc(1);
        chk("expired_once", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        start = 1'b1; pause = 1'b1; cyc(1); start = 1'b0; pause = 1'b0;
        chk("done_ignores", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);

        // Borrow 10 -> 09, then start on 00.
        do_load(4'd1, 4'd0);
        chk("load10", 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("start10", 4'd1, 4'd0, 1'b1, 1'b0, 1'b0);
        cyc(4);
        chk("borrow", 4'd0, 4'd9, 1'b1, 1'b0, 1'b0);
        do_load(4'd0, 4'd0);
        chk("load00", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("start00", 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        cyc(1);
        chk("start00_after", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);

        // Pause and resume from the retained prescaler.
        do_load(4'd0, 4'd5);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("start05", 4'd0, 4'd5, 1'b1, 1'b0, 1'b0);
        cyc(2);
        pause = 1'b1; cyc(1);
        chk("paused", 4'd0, 4'd5, 1'b0, 1'b0, 1'b0);
        cyc(20);
        chk("pause_hold", 4'd0, 4'd5, 1'b0, 1'b0, 1'b0);
        pause = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
        chk("resume", 4'd0, 4'd5, 1'b1, 1'b0, 1'b0);
        cyc(1);
        chk("resume_p1", 4'd0, 4'd5, 1'b1, 1'b0, 1'b0);
        cyc(1);
        chk("resume_dec", 4'd0, 4'd4, 1'b1, 1'b0, 1'b0);

        // Pause beats start; load on a tick cycle discards the tick.
        pause = 1'b1; start = 1'b1; cyc(1); pause = 1'b0; start = 1'b0;
        chk("pause_wins", 4'd0, 4'd4, 1'b0, 1'b0, 1'b0);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("resume2", 4'd0, 4'd4, 1'b1, 1'b0, 1'b0);
        cyc(3);
        chk("pre_tick2", 4'd0, 4'd4, 1'b1, 1'b0, 1'b0);
        do_load(4'd3, 4'd7);
        chk("load_on_tick", 4'd3, 4'd7, 1'b0, 1'b0, 1'b0);

        // Saturating load, then reset mid-RUN just before a tick.
        do_load(4'd12, 4'd15);
        chk("saturate", 4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("start99", 4'd9, 4'd9, 1'b1, 1'b0, 1'b0);
        cyc(4);
        chk("dec98", 4'd9, 4'd8, 1'b1, 1'b0, 1'b0);
        cyc(3);
        reset = 1'b1; cyc(1); reset = 1'b0;
        chk("reset_mid_run", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(4);
        chk("reset_after", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
`else
        // Autoreload: 01 keeps pulsing expired every four cycles.
        do_load(4'd0, 4'd1);
        chk("ar_load01", 4'd0, 4'd1, 1'b0, 1'b0, 1'b0);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("ar_start", 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        cyc(3);
        chk("ar_pre", 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        cyc(1);
        chk("ar_exp1", 4'd0, 4'd1, 1'b1, 1'b0, 1'b1);
        cyc(1);
        chk("ar_after1", 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        cyc(2);
        chk("ar_pre2", 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        cyc(1);
        chk("ar_exp2", 4'd0, 4'd1, 1'b1, 1'b0, 1'b1);
        do_load(4'd0, 4'd0);
        chk("ar_load00", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("ar_zero_done", 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        cyc(1);
        chk("ar_zero_hold", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        do_load(4'd1, 4'd0);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(4);
        chk("ar_borrow", 4'd0, 4'd9, 1'b1, 1'b0, 1'b0);
        reset = 1'b1; cyc(1); reset = 1'b0;
        chk("ar_reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
